// File: rtl/imem_fetch.sv
// Instruction fetch stage: runs the imem read port and hands (pc, inst) to decode with valid/ready.
// Defining IMEM_FETCH_PERF_EN builds the fetch and stall counters; without it both perf ports read zero.
module imem_fetch #(
   parameter logic [31:0] RESET_PC = 32'h1000_0000,
   parameter int          AWIDTH   = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [AWIDTH-1:0] imem_addrb,
   input  logic [31:0]       imem_doutb,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [31:0]       out_pc,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
);

   logic        vld_p0;
   logic [31:0] pc_p0;
   logic        hold_vld_p0;
   logic [31:0] hold_p0;
   logic        handshake;
   logic        stall;
   logic [31:0] req_pc;
   logic [31:0] req_pc_aligned;

   assign handshake = vld_p0 && out_ready;
   assign stall     = vld_p0 && !out_ready;

   // The address issued now is the pc presented next cycle, so imem data lines up with out_pc.
   always_comb begin
      req_pc = pc_p0;
      if (redirect_valid)
         req_pc = redirect_pc;
      else if (handshake)
         req_pc = pc_p0 + 32'd4;
   end

   assign req_pc_aligned = req_pc & 32'hFFFF_FFFC;
   assign imem_addrb     = req_pc[AWIDTH+1:2];

   // ---- stage p0: presented instruction ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0      <= 1'b0;
         pc_p0       <= RESET_PC;
         hold_vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= 1'b1;
         pc_p0  <= req_pc_aligned;
         if (redirect_valid || handshake)
            hold_vld_p0 <= 1'b0;
         else if (stall)
            hold_vld_p0 <= 1'b1;
      end
   end

   // Freeze the word on the first stall cycle so later imem writes cannot alter it.
   always_ff @(posedge clk) begin
      if (stall && !hold_vld_p0)
         hold_p0 <= imem_doutb;
   end

   assign out_valid = vld_p0;
   assign out_pc    = pc_p0;
   assign out_inst  = hold_vld_p0 ? hold_p0 : imem_doutb;

`ifdef IMEM_FETCH_PERF_EN
   logic [31:0] fetch_cnt_p0;
   logic [31:0] stall_cnt_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_p0 <= 32'h0;
         stall_cnt_p0 <= 32'h0;
      end else begin
         if (handshake && !redirect_valid)
            fetch_cnt_p0 <= fetch_cnt_p0 + 32'd1;
         if (stall)
            stall_cnt_p0 <= stall_cnt_p0 + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_p0;
   assign perf_stall_cnt = stall_cnt_p0;
`else
   assign perf_fetch_cnt = 32'h0;
   assign perf_stall_cnt = 32'h0;
`endif

endmodule
